// File: rtl/jk_ff_bank.sv
// Multi-mode (JK/SR/D/T) flip-flop bank with parallel load, sticky illegal-SR flags, optional toggle counter.
// Latency: one clk edge from sampled inputs to every output; all outputs registered.
// Backpressure: none; the bank accepts a new operation on every edge.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   en, mode      enable for mode-driven updates; mode 00 JK, 01 SR, 10 D, 11 T
//   j, k          per-bit J/S/D/T and K/R operands (k ignored in D and T)
//   load, d       parallel load (beats en), load data
//   err_clr       clears sr_err / err_bits (a fresh illegal SR on the same edge still sets them)
//   q, qbar       stored value and its registered complement
//   sr_err        sticky flag: some bit saw S=R=1
//   err_bits      sticky per-bit record of S=R=1
//   tog_cnt       saturating count of q bit flips
//
// Build option: define FF_BANK_TOGCNT_EN to implement tog_cnt; otherwise it is tied to zero.

module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sr_err,
    output logic [WIDTH-1:0] err_bits,
    output logic [CNT_W-1:0] tog_cnt
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] sr_bad;
    logic [WIDTH-1:0] err_bits_nxt;
    logic             sr_err_nxt;

    // Next-state of the storage bits. load overrides en; illegal SR is only
    // flagged when the SR update is actually being applied.
    always_comb begin
        q_nxt  = q;
        sr_bad = '0;
        if (load) begin
            q_nxt = d;
        end else if (en) begin
            case (mode)
                // Q+ = J&~Q | ~K&Q covers hold/clear/set/toggle
                MODE_JK: q_nxt = (j & ~q) | (~k & q);
                // S=R=1 keeps the old value (j^k == 0), same as S=R=0
                MODE_SR: begin
                    q_nxt  = (j & ~k) | (q & ~(j ^ k));
                    sr_bad = j & k;
                end
                MODE_D:  q_nxt = j;
                MODE_T:  q_nxt = q ^ j;
                default: q_nxt = q;
            endcase
        end
    end

    // err_clr wipes the history, but offenders from this very edge survive.
    always_comb begin
        if (err_clr) begin
            err_bits_nxt = sr_bad;
            sr_err_nxt   = |sr_bad;
        end else begin
            err_bits_nxt = err_bits | sr_bad;
            sr_err_nxt   = sr_err | (|sr_bad);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= RST_VAL;
            qbar     <= ~RST_VAL;
            sr_err   <= 1'b0;
            err_bits <= '0;
        end else begin
            q        <= q_nxt;
            qbar     <= ~q_nxt;
            sr_err   <= sr_err_nxt;
            err_bits <= err_bits_nxt;
        end
    end

`ifdef FF_BANK_TOGCNT_EN
    // Sum is carried one bit wider than both operands so overflow past the
    // saturation point is visible before clamping.
    localparam int PCW  = $clog2(WIDTH + 1);
    localparam int SUMW = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
    localparam logic [SUMW-1:0] CNT_MAX = {{(SUMW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    logic [PCW-1:0]   flips;
    logic [SUMW-1:0]  cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        flips   = popcount(q_nxt ^ q);
        cnt_sum = {{(SUMW-CNT_W){1'b0}}, tog_cnt} + {{(SUMW-PCW){1'b0}}, flips};
        if (cnt_sum > CNT_MAX) begin
            cnt_nxt = {CNT_W{1'b1}};
        end else begin
            cnt_nxt = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tog_cnt <= '0;
        end else begin
            tog_cnt <= cnt_nxt;
        end
    end
`else
    assign tog_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_ff_bank.sv
module tb_jk_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic       load;
    logic [7:0] d;
    logic       err_clr;

    logic [7:0]  q0, qbar0, err_bits0;
    logic        sr_err0;
    logic [15:0] tog0;
    logic [7:0]  q1, qbar1, err_bits1;
    logic        sr_err1;
    logic [3:0]  tog1;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [7:0] m_q;
    logic       m_err;
    logic [7:0] m_bits;
    int         m_cnt0;
    int         m_cnt1;

    jk_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .d(d), .err_clr(err_clr),
        .q(q0), .qbar(qbar0), .sr_err(sr_err0), .err_bits(err_bits0), .tog_cnt(tog0)
    );

    jk_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .d(d), .err_clr(err_clr),
        .q(q1), .qbar(qbar1), .sr_err(sr_err1), .err_bits(err_bits1), .tog_cnt(tog1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter expectations depend on whether the counter was built.
    function automatic logic [15:0] exp_cnt(input int c);
`ifdef FF_BANK_TOGCNT_EN
        logic [31:0] v;
        v = c;
        return v[15:0];
`else
        return 16'd0 + 16'(c & 0);
`endif
    endfunction

    // Behavioural reference: applies the operation rules bit by bit.
    task automatic model_edge();
        logic [7:0] nq;
        logic [7:0] bad;
        int         flips;
        if (rst) begin
            m_q = 8'h00; m_err = 1'b0; m_bits = 8'h00; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            nq  = m_q;
            bad = 8'h00;
            if (load) begin
                nq = d;
            end else if (en) begin
                for (int i = 0; i < 8; i++) begin
                    case (mode)
                        2'd0: begin
                            if (j[i] && k[i]) nq[i] = !m_q[i];
                            else if (j[i])    nq[i] = 1'b1;
                            else if (k[i])    nq[i] = 1'b0;
                        end
                        2'd1: begin
                            if (j[i] && k[i]) bad[i] = 1'b1;
                            else if (j[i])    nq[i] = 1'b1;
                            else if (k[i])    nq[i] = 1'b0;
                        end
                        2'd2: nq[i] = j[i];
                        default: if (j[i]) nq[i] = !m_q[i];
                    endcase
                end
            end
            flips = 0;
            for (int i = 0; i < 8; i++) if (nq[i] != m_q[i]) flips++;
            m_cnt0 = (m_cnt0 + flips > 65535) ? 65535 : m_cnt0 + flips;
            m_cnt1 = (m_cnt1 + flips > 15) ? 15 : m_cnt1 + flips;
            if (err_clr) begin
                m_bits = bad;
                m_err  = (bad != 8'h00);
            end else begin
                m_bits = m_bits | bad;
                m_err  = m_err | (bad != 8'h00);
            end
            m_q = nq;
        end
    endtask

    // Inputs are set at the falling edge; outputs are read at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; mode = 2'd0; j = 8'h00; k = 8'h00;
        load = 0; d = 8'h00; err_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; load = 1; d = 8'hFF; en = 1; mode = 2'd3; j = 8'hFF;
        step();
        rst = 0; load = 0; en = 0;
        n_checks++;
        if ({q0, qbar0} !== 16'h00FF) begin
            n_errors++; $display("FAIL reset_q_qbar got %h/%h want 00/ff", q0, qbar0);
        end
        n_checks++;
        if ({sr_err0, err_bits0} !== 9'h000) begin
            n_errors++; $display("FAIL reset_err got %b/%h want 0/00", sr_err0, err_bits0);
        end
        n_checks++;
        if (tog0 !== 16'd0 || tog1 !== 4'd0) begin
            n_errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", tog0, tog1);
        end
    endtask

    task automatic test_jk();
        en = 1; mode = 2'd0; j = 8'hF0; k = 8'h0F;
        step();
        n_checks++;
        if (q0 !== 8'hF0 || tog0 !== exp_cnt(4)) begin
            n_errors++; $display("FAIL jk_set_clr got q=%h cnt=%0d want q=f0 cnt=%0d", q0, tog0, exp_cnt(4));
        end
        j = 8'hFF; k = 8'hFF;
        step();
        n_checks++;
        if (q0 !== 8'h0F || qbar0 !== 8'hF0 || tog0 !== exp_cnt(12)) begin
            n_errors++; $display("FAIL jk_toggle got q=%h qbar=%h cnt=%0d want 0f/f0/%0d", q0, qbar0, tog0, exp_cnt(12));
        end
    endtask

    task automatic test_sr_illegal();
        mode = 2'd1; j = 8'h81; k = 8'h01;
        step();
        n_checks++;
        if (q0 !== 8'h8F || sr_err0 !== 1'b1 || err_bits0 !== 8'h01) begin
            n_errors++; $display("FAIL sr_illegal got q=%h err=%b bits=%h want 8f/1/01", q0, sr_err0, err_bits0);
        end
        err_clr = 1; j = 8'h02; k = 8'h02;
        step();
        err_clr = 0;
        n_checks++;
        if (q0 !== 8'h8F || sr_err0 !== 1'b1 || err_bits0 !== 8'h02) begin
            n_errors++; $display("FAIL sr_clr_collide got q=%h err=%b bits=%h want 8f/1/02", q0, sr_err0, err_bits0);
        end
        err_clr = 1; j = 8'h00; k = 8'h00;
        step();
        err_clr = 0;
        n_checks++;
        if (sr_err0 !== 1'b0 || err_bits0 !== 8'h00) begin
            n_errors++; $display("FAIL sr_clr got err=%b bits=%h want 0/00", sr_err0, err_bits0);
        end
    endtask

    task automatic test_load_en();
        en = 0; load = 1; d = 8'hA5; mode = 2'd1; j = 8'hFF; k = 8'hFF;
        step();
        n_checks++;
        if (q0 !== 8'hA5 || sr_err0 !== 1'b0 || tog0 !== exp_cnt(16)) begin
            n_errors++; $display("FAIL load got q=%h err=%b cnt=%0d want a5/0/%0d", q0, sr_err0, tog0, exp_cnt(16));
        end
        load = 0; mode = 2'd3; j = 8'hFF; k = 8'h00;
        step();
        n_checks++;
        if (q0 !== 8'hA5) begin
            n_errors++; $display("FAIL en_low_hold got q=%h want a5", q0);
        end
        en = 1;
        step();
        n_checks++;
        if (q0 !== 8'h5A || qbar0 !== 8'hA5) begin
            n_errors++; $display("FAIL t_after_en got q=%h qbar=%h want 5a/a5", q0, qbar0);
        end
    endtask

    task automatic test_dt();
        mode = 2'd2; j = 8'h3C; k = 8'hFF;
        step();
        n_checks++;
        if (q0 !== 8'h3C || tog0 !== exp_cnt(28)) begin
            n_errors++; $display("FAIL d_mode got q=%h cnt=%0d want 3c/%0d", q0, tog0, exp_cnt(28));
        end
        mode = 2'd3; j = 8'h0F;
        step();
        n_checks++;
        if (q0 !== 8'h33 || tog0 !== exp_cnt(32)) begin
            n_errors++; $display("FAIL t_mode got q=%h cnt=%0d want 33/%0d", q0, tog0, exp_cnt(32));
        end
    endtask

    task automatic test_saturation();
        logic [15:0] want;
        idle_inputs();
        rst = 1;
        step();
        rst = 0; en = 1; mode = 2'd3; j = 8'hFF;
        step();
        step();
        want = exp_cnt(15);
        n_checks++;
        if (tog1 !== want[3:0] || tog0 !== exp_cnt(16)) begin
            n_errors++; $display("FAIL sat_reach got %0d/%0d want %0d/%0d", tog1, tog0, want[3:0], exp_cnt(16));
        end
        step();
        step();
        n_checks++;
        if (tog1 !== want[3:0] || q1 !== 8'h00) begin
            n_errors++; $display("FAIL sat_hold got cnt=%0d q=%h want %0d/00", tog1, q1, want[3:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w1;
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 31) == 0);
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 7) == 0);
            mode    = 2'($urandom_range(0, 3));
            j       = 8'($urandom);
            k       = 8'($urandom);
            d       = 8'($urandom);
            step();
            w1 = exp_cnt(m_cnt1);
            n_checks++;
            if (q0 !== m_q || qbar0 !== ~m_q || q1 !== m_q || qbar1 !== ~m_q) begin
                n_errors++; $display("FAIL rand_q cyc %0d got %h/%h/%h want %h/%h", n, q0, qbar0, q1, m_q, ~m_q);
            end
            n_checks++;
            if (sr_err0 !== m_err || err_bits0 !== m_bits || sr_err1 !== m_err || err_bits1 !== m_bits) begin
                n_errors++; $display("FAIL rand_err cyc %0d got %b/%h want %b/%h", n, sr_err0, err_bits0, m_err, m_bits);
            end
            n_checks++;
            if (tog0 !== exp_cnt(m_cnt0) || tog1 !== w1[3:0]) begin
                n_errors++; $display("FAIL rand_cnt cyc %0d got %0d/%0d want %0d/%0d", n, tog0, tog1, exp_cnt(m_cnt0), w1[3:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        m_q = 8'h00; m_err = 1'b0; m_bits = 8'h00; m_cnt0 = 0; m_cnt1 = 0;
        @(negedge clk);
        test_reset();
        test_jk();
        test_sr_illegal();
        test_load_en();
        test_dt();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
